// File: rtl/updi_phy_rx.sv
// rtl/updi_phy_rx.sv - UPDI receive PHY: deserialises line frames into 12-bit frame memory words
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   ren               receive enable; low holds the block idle and clears pointer/flags
//   rxd               asynchronous UPDI line, idles high
//   csb0, web0        memory chip select / write enable, active-low
//   addr0             memory word address (write pointer)
//   o_data            write word {1'b0, brk, ferr, perr, data[7:0]}
//   rend              one-cycle pulse on buffer full or idle timeout
//   busy              high from start-bit detection until the frame is written or dropped
//   frame_cnt         frames written since enable
//   ovf               sticky: a frame arrived while the buffer was full
module updi_phy_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_W       = 7,
  parameter int IDLE_BITS    = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ren,
  input  logic              rxd,
  output logic              csb0,
  output logic              web0,
  output logic [ADDR_W-1:0] addr0,
  output logic [11:0]       o_data,
  output logic              rend,
  output logic              busy,
  output logic [ADDR_W:0]   frame_cnt,
  output logic              ovf
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  // The timeout counter is preloaded at the write so that the pulse lands
  // IDLE_BITS bit periods after the end of the second stop bit (the write
  // happens half a bit period minus one cycle before that point).
  localparam int IDLE_LOAD   = IDLE_BITS * CLKS_PER_BIT + CLKS_PER_BIT / 2 - 3;
  localparam int IDLE_RELOAD = IDLE_BITS * CLKS_PER_BIT - 1;
  localparam int IDLE_W      = $clog2(IDLE_LOAD + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WRITE, S_WAIT_HIGH
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rx_meta;
  logic              r_rxs;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_bitn;
  logic [7:0]        r_shift;
  logic              r_par;
  logic              r_stop1;
  logic              r_stop2;
  logic              r_zero;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_frame_cnt;
  logic              r_full;
  logic              r_ovf;
  logic              r_armed;
  logic              r_rend;
  logic [IDLE_W-1:0] r_idle;

  logic              w_tick;
  logic              w_wr;
  logic              w_brk;
  logic              w_perr;
  logic              w_ferr;
  logic [11:0]       w_word;

  // Two-stage synchroniser; held at the idle level through reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rxd;
      r_rxs     <= r_rx_meta;
    end
  end

  assign w_tick = (r_cnt == '0);

  // State register
  always_ff @(posedge clk) begin
    if (rst || !ren) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:      if (!r_rxs) w_state_nxt = S_START;
      S_START:     if (w_tick) w_state_nxt = r_rxs ? S_IDLE : S_DATA;
      S_DATA:      if (w_tick && r_bitn == 3'd7) w_state_nxt = S_PARITY;
      S_PARITY:    if (w_tick) w_state_nxt = S_STOP1;
      S_STOP1:     if (w_tick) w_state_nxt = S_STOP2;
      S_STOP2:     if (w_tick) w_state_nxt = S_WRITE;
      S_WRITE:     w_state_nxt = r_zero ? S_WAIT_HIGH : S_IDLE;
      S_WAIT_HIGH: if (r_rxs && w_tick) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Bit timing and sample capture
  always_ff @(posedge clk) begin
    if (rst || !ren) begin
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_stop1 <= 1'b0;
      r_stop2 <= 1'b0;
      r_zero  <= 1'b1;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // Half-bit load puts every later sample mid-bit.
          r_cnt  <= CNT_HALF;
          r_bitn <= '0;
          r_zero <= 1'b1;
        end
        S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2: begin
          r_cnt <= w_tick ? CNT_FULL : r_cnt - 1'b1;
          if (w_tick) begin
            r_zero <= r_zero & ~r_rxs;
            unique case (r_state)
              S_DATA: begin
                r_shift <= {r_rxs, r_shift[7:1]};
                r_bitn  <= r_bitn + 1'b1;
              end
              S_PARITY: r_par   <= r_rxs;
              S_STOP1:  r_stop1 <= r_rxs;
              S_STOP2:  r_stop2 <= r_rxs;
              default: ;
            endcase
          end
        end
        S_WRITE: r_cnt <= CNT_FULL;
        S_WAIT_HIGH: begin
          // Any low sample restarts the full high-bit requirement.
          if (!r_rxs)       r_cnt <= CNT_FULL;
          else if (!w_tick) r_cnt <= r_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A frame of all-zero samples is a BREAK and carries no parity/framing error.
  assign w_brk  = r_zero;
  assign w_perr = ~r_zero & ((^r_shift) ^ r_par);
  assign w_ferr = ~r_zero & ~(r_stop1 & r_stop2);
  assign w_word = {1'b0, w_brk, w_ferr, w_perr, r_shift};

  // Frames tracked while full pass through WRITE without touching memory.
  assign w_wr = (r_state == S_WRITE) && !r_full && ren && !rst;

  // Write pointer, flags and idle timeout
  always_ff @(posedge clk) begin
    if (rst || !ren) begin
      r_wr_ptr    <= '0;
      r_frame_cnt <= '0;
      r_full      <= 1'b0;
      r_ovf       <= 1'b0;
      r_armed     <= 1'b0;
      r_rend      <= 1'b0;
      r_idle      <= IDLE_W'(IDLE_RELOAD);
    end else begin
      r_rend <= 1'b0;
      if (w_wr) begin
        r_wr_ptr    <= r_wr_ptr + 1'b1;
        r_frame_cnt <= r_frame_cnt + 1'b1;
        r_armed     <= 1'b1;
        r_idle      <= IDLE_W'(IDLE_LOAD);
        if (&r_wr_ptr) begin
          r_full <= 1'b1;
          r_rend <= 1'b1;
        end
      end else begin
        if (!r_rxs)             r_idle <= IDLE_W'(IDLE_RELOAD);
        else if (r_idle != '0)  r_idle <= r_idle - 1'b1;
        if (r_armed && !r_full && r_rxs && r_idle == '0) begin
          r_rend  <= 1'b1;
          r_armed <= 1'b0;
        end
      end
      if (r_state == S_IDLE && !r_rxs && r_full) r_ovf <= 1'b1;
    end
  end

  // Output logic
  always_comb begin
    busy      = (r_state != S_IDLE) && (r_state != S_WAIT_HIGH);
    csb0      = ~w_wr;
    web0      = ~w_wr;
    addr0     = r_wr_ptr;
    o_data    = w_wr ? w_word : 12'h000;
    rend      = r_rend;
    frame_cnt = r_frame_cnt;
    ovf       = r_ovf;
  end

endmodule

// File: tb/tb_updi_phy_rx.sv
// tb/tb_updi_phy_rx.sv - directed and random frame checks for updi_phy_rx against a frame-level model
module tb_updi_phy_rx;

  localparam int CPB   = 16;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ren;
  logic          rxd;
  logic          csb0;
  logic          web0;
  logic [AW-1:0] addr0;
  logic [11:0]   o_data;
  logic          rend;
  logic          busy;
  logic [AW:0]   frame_cnt;
  logic          ovf;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int wq_a[$];
  int wq_d[$];
  int wq_t[$];
  int rq[$];

  int m_ptr  = 0;
  int m_cnt  = 0;
  bit m_full = 1'b0;
  bit m_ovf  = 1'b0;

  updi_phy_rx #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .IDLE_BITS(24)) dut (
    .clk(clk), .rst(rst), .ren(ren), .rxd(rxd),
    .csb0(csb0), .web0(web0), .addr0(addr0), .o_data(o_data),
    .rend(rend), .busy(busy), .frame_cnt(frame_cnt), .ovf(ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (csb0 === 1'b0 && web0 === 1'b0) begin
      wq_a.push_back(int'(addr0));
      wq_d.push_back(int'(o_data));
      wq_t.push_back(cyc);
    end
    if (rend === 1'b1) rq.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected memory word for a transmitted 12-bit frame {s2, s1, par, data, start}.
  function automatic logic [11:0] exp_word(input logic [11:0] f);
    if (f == 12'h000) return 12'h400;
    return {2'b00, ~(f[10] & f[11]), (^f[8:1]) ^ f[9], f[8:1]};
  endfunction

  function automatic logic [11:0] mk(input logic [7:0] d, input logic p, input logic s1, input logic s2);
    return {s2, s1, p, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [11:0] bits, input int n, output int s);
    @(posedge clk); #1;
    s = cyc;
    for (int i = 0; i < n; i++) begin
      rxd = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [11:0] f, output int s);
    send_bits(f, 12, s);
    rxd = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  // Synchronised start edge is 2 cycles after the line edge; write 185 cycles later.
  task automatic expect_frame(input int s, input logic [11:0] f);
    if (m_full) begin
      chk("no_write_when_full", wq_a.size(), 0);
      m_ovf = 1'b1;
    end else begin
      chk("write_count", wq_a.size(), 1);
      if (wq_a.size() > 0) begin
        chk("write_addr", wq_a[0], m_ptr);
        chk("write_data", wq_d[0], exp_word(f));
        chk("write_time", wq_t[0], s + 187);
      end
      m_ptr = (m_ptr + 1) % DEPTH;
      m_cnt++;
      if (m_ptr == 0) m_full = 1'b1;
    end
    wq_a.delete(); wq_d.delete(); wq_t.delete();
    chk("frame_cnt", frame_cnt, m_cnt);
    chk("ovf", ovf, m_ovf);
  endtask

  task automatic ren_cycle();
    ren = 1'b0;
    @(posedge clk); #1;
    ren = 1'b1;
    m_ptr = 0; m_cnt = 0; m_full = 1'b0; m_ovf = 1'b0;
    chk("ren_clr_frame_cnt", frame_cnt, 0);
    chk("ren_clr_ovf", ovf, 0);
    chk("ren_clr_addr", addr0, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_csb0"}, csb0, 1);
    chk({tag, "_web0"}, web0, 1);
    chk({tag, "_addr0"}, addr0, 0);
    chk({tag, "_o_data"}, o_data, 0);
    chk({tag, "_rend"}, rend, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  initial begin
    int s;
    int bcnt;
    logic [11:0] f;
    logic [7:0]  d;
    logic        p;
    logic        s1;

    rst = 1'b1; ren = 1'b1; rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // First frame, then idle line: timeout pulse 384 cycles after stop2 ends.
    rq.delete();
    f = mk(8'h55, 1'b0, 1'b1, 1'b1);
    send_frame(f, s);
    expect_frame(s, f);
    while (cyc < s + 600) @(posedge clk);
    #1;
    chk("idle_rend_count", rq.size(), 1);
    if (rq.size() > 0) chk("idle_rend_time", rq[0], s + 578);

    // Parity error and a good odd-weight frame.
    f = mk(8'hA5, 1'b1, 1'b1, 1'b1);
    send_frame(f, s);
    expect_frame(s, f);
    f = mk(8'h01, 1'b1, 1'b1, 1'b1);
    send_frame(f, s);
    expect_frame(s, f);

    // Glitch: 4 low cycles must be rejected after half a bit.
    @(posedge clk); #1;
    bcnt = 0;
    for (int i = 0; i < 34; i++) begin
      rxd = (i < 4) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      if (busy === 1'b1) bcnt++;
    end
    chk("glitch_busy_cycles", bcnt, CPB / 2);
    chk("glitch_no_write", wq_a.size(), 0);
    chk("glitch_frame_cnt", frame_cnt, m_cnt);

    ren_cycle();

    // Framing error on stop2.
    f = mk(8'h3C, 1'b0, 1'b1, 1'b0);
    send_frame(f, s);
    expect_frame(s, f);

    // BREAK, then a short low pulse before the line has been high a full bit.
    send_bits(12'h000, 12, s);
    bcnt = 0;
    for (int i = 0; i < 52; i++) begin
      rxd = (i >= 8 && i < 12) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      if (busy === 1'b1) bcnt++;
    end
    chk("break_wait_busy", bcnt, 0);
    expect_frame(s, 12'h000);

    f = mk(8'h5A, 1'b0, 1'b1, 1'b1);
    send_frame(f, s);
    expect_frame(s, f);

    // Fourth write fills the buffer and pulses rend once.
    rq.delete();
    d = 8'($urandom); p = 1'($urandom); s1 = 1'($urandom);
    f = mk(d, p, s1, 1'b1);
    send_frame(f, s);
    expect_frame(s, f);
    chk("full_rend_count", rq.size(), 1);
    if (rq.size() > 0) chk("full_rend_time", rq[0], s + 188);

    // Fifth frame while full is dropped and sets ovf.
    d = 8'($urandom); p = 1'($urandom);
    f = mk(d, p, 1'b1, 1'b1);
    send_frame(f, s);
    expect_frame(s, f);

    ren_cycle();

    // Random frames after re-enable start again at address 0.
    for (int k = 0; k < 3; k++) begin
      d = 8'($urandom); p = 1'($urandom); s1 = ($urandom_range(3) != 0);
      f = mk(d, p, s1, 1'b1);
      send_frame(f, s);
      expect_frame(s, f);
    end

    // Reset in the middle of a frame.
    send_bits(12'b0000_0001_1010, 5, s);
    rst = 1'b1;
    rxd = 1'b1;
    @(posedge clk); #1;
    chk_reset_outputs("midrst");
    rst = 1'b0;
    m_ptr = 0; m_cnt = 0; m_full = 1'b0; m_ovf = 1'b0;
    repeat (250) @(posedge clk);
    #1;
    chk("midrst_no_write", wq_a.size(), 0);
    chk("midrst_frame_cnt", frame_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
